// File: rtl/lockout_timer.sv
// Escalating lockout countdown: each accepted start runs for min(BASE_SECS << level, MAX_SECS)
// seconds, timed by a prescaler tick, then holds in DONE until the next start.
module lockout_timer #(
    parameter int   TICK_DIV  = 50_000_000,
    parameter int   BASE_SECS = 60,
    parameter int   MAX_SECS  = 240,
    parameter int   LEVELS    = 4,
    localparam int  LVW       = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           clear_level,
    output logic           busy,
    output logic           done,
    output logic [9:0]     remaining,
    output logic [3:0]     bcd_hun,
    output logic [3:0]     bcd_ten,
    output logic [3:0]     bcd_one,
    output logic [LVW-1:0] level,
    output logic [1:0]     state_dbg
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [9:0]     rem_q, rem_d;
    logic [LVW-1:0] level_q, level_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           tick;
    logic [LVW-1:0] lvl_eff;
    logic [LVW-1:0] lvl_next;
    int             lvl_int;
    int             shifted;
    int             dur_int;

    assign tick = (state_q == S_COUNT) && (presc_q == PW'(TICK_DIV - 1));

    // A clear arriving with a start applies first, so the duration uses level 0.
    always_comb begin
        lvl_eff  = clear_level ? '0 : level_q;
        lvl_next = (lvl_eff == LVW'(LEVELS - 1)) ? lvl_eff : lvl_eff + 1'b1;
        lvl_int  = int'(lvl_eff);
        shifted  = 0;
        dur_int  = MAX_SECS;
        if (lvl_int < 10) begin
            shifted = BASE_SECS << lvl_int;
            dur_int = (shifted > MAX_SECS) ? MAX_SECS : shifted;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        level_d = level_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                presc_d = '0;
                if (start) begin
                    state_d = S_COUNT;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    rem_d   = 10'(dur_int);
                    level_d = lvl_next;
                end else if (clear_level) begin
                    level_d = '0;
                end
            end
            S_COUNT: begin
                if (clear_level) level_d = '0;
                if (tick) begin
                    presc_d = '0;
                    if (rem_q <= 10'd1) begin
                        rem_d   = '0;
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - 10'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            rem_q   <= '0;
            level_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;
    assign level     = level_q;
    assign state_dbg = state_q;

    assign bcd_hun = 4'(rem_q / 10'd100);
    assign bcd_ten = 4'((rem_q / 10'd10) % 10'd10);
    assign bcd_one = 4'(rem_q % 10'd10);

endmodule

// File: tb/tb_lockout_timer.sv
// Directed plus randomized checks of lockout_timer against a cycle-count model of the lockout rules.
module tb_lockout_timer;

    localparam int TD = 4;
    localparam int BS = 60;
    localparam int MS = 240;
    localparam int LV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear_level;
    logic       busy;
    logic       done;
    logic [9:0] remaining;
    logic [3:0] bcd_hun;
    logic [3:0] bcd_ten;
    logic [3:0] bcd_one;
    logic [1:0] level;
    logic [1:0] state_dbg;

    lockout_timer #(
        .TICK_DIV (TD),
        .BASE_SECS(BS),
        .MAX_SECS (MS),
        .LEVELS   (LV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear_level(clear_level),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .bcd_hun    (bcd_hun),
        .bcd_ten    (bcd_ten),
        .bcd_one    (bcd_one),
        .level      (level),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: a lockout is "elapsed cycles since start"; remaining = dur - elapsed/TD.
    int m_level   = 0;
    int m_dur     = 0;
    int m_elapsed = 0;
    int m_rem     = 0;
    int m_busy    = 0;
    int m_done    = 0;

    function automatic int dur_for(input int lv);
        int d;
        d = BS << lv;
        return (d > MS) ? MS : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("busy",      32'(busy),      32'(m_busy));
        check("done",      32'(done),      32'(m_done));
        check("remaining", 32'(remaining), 32'(m_rem));
        check("bcd_hun",   32'(bcd_hun),   32'(m_rem / 100));
        check("bcd_ten",   32'(bcd_ten),   32'((m_rem / 10) % 10));
        check("bcd_one",   32'(bcd_one),   32'(m_rem % 10));
        check("level",     32'(level),     32'(m_level));
    endtask

    task automatic model_reset();
        m_level = 0; m_dur = 0; m_elapsed = 0; m_rem = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic step(input bit s, input bit c);
        int lv;
        start       = s;
        clear_level = c;
        @(posedge clk);
        if (m_busy != 0) begin
            m_elapsed++;
            if (c) m_level = 0;
            if (m_elapsed == m_dur * TD) begin
                m_busy = 0; m_done = 1; m_rem = 0;
            end else begin
                m_rem = m_dur - m_elapsed / TD;
            end
        end else if (s) begin
            lv        = c ? 0 : m_level;
            m_dur     = dur_for(lv);
            m_level   = (lv + 1 > LV - 1) ? LV - 1 : lv + 1;
            m_busy    = 1;
            m_done    = 0;
            m_elapsed = 0;
            m_rem     = m_dur;
        end else if (c) begin
            m_level = 0;
        end
        #1;
        start       = 1'b0;
        clear_level = 1'b0;
        check_all();
    endtask

    task automatic run_to_done();
        int budget;
        budget = 4000;
        while (m_done == 0 && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic run_until_rem(input int r);
        int budget;
        budget = 4000;
        while (m_rem != r && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        check("rem_reached", 32'(remaining), 32'(r));
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        clear_level = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 reset = 1'b1;

        // First lockout from reset: 60 s, done after 240 cycles.
        step(1'b1, 1'b0);
        run_until_rem(59);
        run_to_done();

        // Back-to-back lockouts started in DONE: 120, 240, 240.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            run_to_done();
        end

        // Start pulse mid-count is ignored.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        run_until_rem(37);
        step(1'b1, 1'b0);
        run_until_rem(36);
        run_to_done();

        // clear_level mid-count does not disturb the countdown.
        step(1'b1, 1'b0);
        run_until_rem(100);
        step(1'b0, 1'b1);
        run_to_done();
        step(1'b1, 1'b0);
        run_to_done();

        // Climb to level 3, then start together with clear.
        step(1'b1, 1'b0);
        run_to_done();
        step(1'b1, 1'b0);
        run_to_done();
        step(1'b1, 1'b1);
        run_to_done();

        // Asynchronous reset mid-count at remaining=100.
        step(1'b1, 1'b0);
        run_until_rem(100);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #3 reset = 1'b1;
        repeat (10) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_to_done();

        // Randomized start/clear traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
